simd_v2: RTL and testbench
==========================

SIMD_V2 -- requirements
Module: simd_v2

Interface
REQ-001 Parameter BW, default 8: lane and bus data width in bits; BW SHALL be at least 8.
REQ-002 Parameter LANES, default 32: number of operand lanes per bank.
REQ-003 Parameter PAR, default 4: lanes computed per clock; LANES SHALL be a multiple of PAR.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 cs  input  1  chip select; it qualifies wr, rd and start.
REQ-007 wr  input  1  write strobe; each cycle with cs&wr high is one write.
REQ-008 rd  input  1  read strobe; each cycle with cs&rd high is one read.
REQ-009 ad  input  1  1 = data_in is an address, 0 = data_in is data.
REQ-010 start  input  1  execute request, sampled when cs is high.
REQ-011 data_in  input  BW  host write data or address.
REQ-012 data_out  output  BW  registered read data.
REQ-013 busy  output  1  high while the engine is computing.

Function
REQ-014 Address map: 0..LANES-1 is bank A, LANES..2*LANES-1 is bank B, MODE=2*LANES, STAT=2*LANES+1 (read-only), RES=2*LANES+2 (read-only).
REQ-015 A write with ad=1 SHALL load the 8-bit address register; a data write (ad=0) SHALL write the addressed register and then increment the address register modulo 256.
REQ-016 Data writes to unmapped, STAT or RES addresses SHALL have no effect on data registers but SHALL still increment the address register.
REQ-017 MODE[1:0] selects the operation: 00 add, 01 sub, 10 mul, 11 mac; all results are truncated to BW bits (wrap-around).
REQ-018 Per-lane operations: add R=A+B; sub R=A-B; mul R=low BW bits of A*B; mac R=R+A*B, using the previous R.
REQ-019 FSM states are IDLE, EXEC and DONE; reset enters IDLE.
REQ-020 cs&start in IDLE or DONE SHALL enter EXEC, clear the lane counter and clear the result pointer.
REQ-021 In EXEC, PAR lanes SHALL be computed per cycle in ascending lane order; after LANES/PAR cycles the FSM SHALL enter DONE.
REQ-022 busy SHALL be 1 exactly while in EXEC.
REQ-023 cs&start while in EXEC SHALL be ignored and SHALL set the sticky err bit.
REQ-024 Writes to A, B or MODE while in EXEC, or in the same cycle start is accepted, SHALL be dropped and SHALL set err.
REQ-025 Reads SHALL return data on data_out in the cycle after the strobe; data_out SHALL hold its value otherwise.
REQ-026 Reads of A, B or MODE return the register value; a read of STAT returns {0..., err, done, busy} in bits [2:0] and then clears err.
REQ-027 A read of RES returns R[ptr] and then increments ptr, wrapping from LANES-1 to 0; in EXEC it returns 0 and ptr does not move.
REQ-028 Reads SHALL NOT increment the address register.
REQ-029 If wr and rd are both high in one cycle, the write SHALL be performed and the read ignored.

Reset
REQ-030 rst_n low SHALL clear the address register, A, B, MODE, R, ptr, the lane counter, err, data_out and busy to 0, and set the FSM to IDLE, including mid-EXEC.

Structure
REQ-031 Package simd_pkg SHALL hold the mode encoding, the FSM state encoding and the address-map constants as functions of LANES.
REQ-032 Sub-module simd_lane SHALL implement one combinational lane ALU; simd_v2 SHALL instantiate PAR copies.

Verification
REQ-033 Defaults; A[i]=i, B[i]=2, MODE=00, start -> busy for 8 cycles; RES reads return 2,3,...,33.
REQ-034 MODE=11 with A=B=16 in every lane, start twice -> every lane reads 0x00 (256+256 wraps to 0 at BW=8).
REQ-035 MODE=01 with A=1, B=2 -> every lane reads 0xFF; after 33 RES reads the ptr has wrapped and lane 0 is returned again.
REQ-036 A write to A[0] and a repeated start during EXEC -> both ignored, STAT=0b101, and the next STAT read shows err cleared.
REQ-037 rst_n pulsed low at EXEC cycle 3 -> busy=0 and data_out=0 immediately; a STAT read afterwards returns 0.

Source files
------------

// File: rtl/simd_pkg.sv
// simd_v2 shared types: op modes, FSM states, status bundle, address map.
// Map addresses are derived from the lane count.
package simd_pkg;

  localparam int AW = 8;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_MUL = 2'b10,
    MODE_MAC = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic err;
    logic done;
    logic busy;
  } stat_t;

  function automatic int b_base(int lanes);
    return lanes;
  endfunction

  function automatic int mode_addr(int lanes);
    return 2 * lanes;
  endfunction

  function automatic int stat_addr(int lanes);
    return 2 * lanes + 1;
  endfunction

  function automatic int res_addr(int lanes);
    return 2 * lanes + 2;
  endfunction

endpackage

// File: rtl/simd_v2_if.sv
// Host bus for simd_v2: chip-select qualified strobes,
// shared address/data input and registered read data.
interface simd_v2_if #(
  parameter int BW = 8
);
  logic          cs;
  logic          wr;
  logic          rd;
  logic          ad;
  logic          start;
  logic [BW-1:0] data_in;
  logic [BW-1:0] data_out;
  logic          busy;

  modport master (
    output cs, wr, rd, ad, start, data_in,
    input  data_out, busy
  );

  modport slave (
    input  cs, wr, rd, ad, start, data_in,
    output data_out, busy
  );
endinterface

// File: rtl/simd_lane.sv
// One combinational lane ALU; results wrap at BW bits.
// mac accumulates onto the lane's previous result.
module simd_lane
  import simd_pkg::*;
#(
  parameter int BW = 8
) (
  input  mode_e         mode,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] r,
  output logic [BW-1:0] y
);

  always_comb begin
    y = '0;
    unique case (mode)
      MODE_ADD: y = a + b;
      MODE_SUB: y = a - b;
      MODE_MUL: y = a * b;
      MODE_MAC: y = r + a * b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/simd_v2.sv
// Banked SIMD engine: host-loaded A/B banks, PAR lanes per clock,
// results drained through an auto-incrementing RES window.
module simd_v2
  import simd_pkg::*;
#(
  parameter int BW    = 8,
  parameter int LANES = 32,
  parameter int PAR   = 4
) (
  input logic       clk,
  input logic       rst_n,
  simd_v2_if.slave  bus
);

  localparam int STEPS = LANES / PAR;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [AW-1:0] LB = AW'(b_base(LANES));
  localparam logic [AW-1:0] LE = AW'(mode_addr(LANES));
  localparam logic [AW-1:0] MA = AW'(mode_addr(LANES));
  localparam logic [AW-1:0] SA = AW'(stat_addr(LANES));
  localparam logic [AW-1:0] RA = AW'(res_addr(LANES));

  state_e state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [BW-1:0] mode_q;
  logic [BW-1:0] dout_q;
  logic          err_q;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;

  logic [BW-1:0] a_q [LANES];
  logic [BW-1:0] b_q [LANES];
  logic [BW-1:0] r_q [LANES];

  logic [IW-1:0] idx [PAR];
  logic [BW-1:0] y   [PAR];

  logic hit_a, hit_b, hit_m, hit_s, hit_r;
  logic [IW-1:0] a_idx, b_idx;
  logic wr_en, rd_en, start_req, start_ok;
  logic protect, wr_ok, err_set, busy;
  logic [BW-1:0] rd_val;
  stat_t stat;

  assign busy      = (state_q == S_EXEC);
  assign wr_en     = bus.cs & bus.wr;
  assign rd_en     = bus.cs & bus.rd & ~bus.wr;
  assign start_req = bus.cs & bus.start;
  assign start_ok  = start_req & ~busy;

  always_comb begin
    hit_a = (addr_q < LB);
    hit_b = !hit_a && (addr_q < LE);
    hit_m = (addr_q == MA);
    hit_s = (addr_q == SA);
    hit_r = (addr_q == RA);
    a_idx = IW'(addr_q);
    b_idx = IW'(addr_q - LB);
  end

  // Bank/MODE writes are frozen for the whole run, start cycle included.
  assign protect = busy | start_ok;
  assign wr_ok   = wr_en & ~bus.ad & ~protect;
  assign err_set = (wr_en & ~bus.ad & protect & (hit_a | hit_b | hit_m))
                 | (start_req & busy);

  assign stat = '{err: err_q, done: (state_q == S_DONE), busy: busy};

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_a:   rd_val = a_q[a_idx];
      hit_b:   rd_val = b_q[b_idx];
      hit_m:   rd_val = mode_q;
      hit_s:   rd_val = {{(BW-3){1'b0}}, stat};
      hit_r:   rd_val = busy ? '0 : r_q[ptr_q];
      default: rd_val = '0;
    endcase
  end

  for (genvar j = 0; j < PAR; j++) begin : g_lane
    assign idx[j] = IW'(int'(cnt_q) * PAR + j);
    simd_lane #(.BW(BW)) u_lane (
      .mode (mode_e'(mode_q[1:0])),
      .a    (a_q[idx[j]]),
      .b    (b_q[idx[j]]),
      .r    (r_q[idx[j]]),
      .y    (y[j])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_req) state_d = S_EXEC;
      S_EXEC: if (cnt_q == CW'(STEPS - 1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      mode_q <= '0;
      dout_q <= '0;
      err_q  <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      if (wr_en && bus.ad)  addr_q <= bus.data_in[AW-1:0];
      if (wr_en && !bus.ad) addr_q <= addr_q + 1'b1;
      if (wr_ok) begin
        unique case (1'b1)
          hit_a:   a_q[a_idx] <= bus.data_in;
          hit_b:   b_q[b_idx] <= bus.data_in;
          hit_m:   mode_q     <= bus.data_in;
          default: ;
        endcase
      end
      if (rd_en) dout_q <= rd_val;
      if (err_set)             err_q <= 1'b1;
      else if (rd_en && hit_s) err_q <= 1'b0;
      if (start_ok) begin
        cnt_q <= '0;
        ptr_q <= '0;
      end else begin
        if (busy) cnt_q <= cnt_q + 1'b1;
        if (rd_en && hit_r && !busy)
          ptr_q <= (ptr_q == IW'(LANES - 1)) ? '0 : ptr_q + 1'b1;
      end
      if (busy) begin
        for (int j = 0; j < PAR; j++) r_q[idx[j]] <= y[j];
      end
    end
  end

  assign bus.data_out = dout_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_simd_v2.sv
// Directed bench for simd_v2: reads push expectations into a
// scoreboard that a monitor drains from the registered read data.
module tb_simd_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_v2_if #(.BW(8)) bus ();

  simd_v2 #(.BW(8), .LANES(32), .PAR(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] v;
    string      n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int n;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && bus.cs && bus.rd && !bus.wr) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read: got %0h want none", bus.data_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.n, bus.data_out, e.v);
        end
      end
    end
  end

  task automatic idle();
    bus.cs = 0; bus.wr = 0; bus.rd = 0;
    bus.ad = 0; bus.start = 0; bus.data_in = '0;
  endtask

  task automatic wa(input int a);
    bus.cs = 1; bus.wr = 1; bus.ad = 1; bus.data_in = 8'(a);
    @(negedge clk);
    idle();
  endtask

  task automatic wd(input int d);
    bus.cs = 1; bus.wr = 1; bus.ad = 0; bus.data_in = 8'(d);
    @(negedge clk);
    idle();
  endtask

  task automatic rx(input int v, input string nm);
    sb.push_back('{8'(v), nm});
    bus.cs = 1; bus.rd = 1;
    @(negedge clk);
    idle();
  endtask

  task automatic go();
    bus.cs = 1; bus.start = 1;
    @(negedge clk);
    idle();
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (bus.busy) begin
      failures++;
      $display("FAIL busy_timeout: got 1 want 0");
    end
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(negedge clk);
    chk("rst_busy", {7'b0, bus.busy}, 8'h00);
    chk("rst_dout", bus.data_out, 8'h00);
    rst_n = 1;
    @(negedge clk);

    // add: A[i]=i, B[i]=2
    wa(0);
    for (int i = 0; i < 32; i++) wd(i);
    for (int i = 0; i < 32; i++) wd(2);
    wd(0);
    wa(64); rx(0, "mode_rb");
    wa(5);  rx(5, "a5_rb");
    wa(35); rx(2, "b3_rb");
    go();
    wait_done(n);
    chk("busy_cycles", 8'(n), 8'd8);
    wa(65); rx(2, "stat_done");
    wa(66);
    for (int i = 0; i < 32; i++) rx(i + 2, "res_add");
    rx(2, "res_add_wrap");

    // simultaneous wr+rd: write wins, data_out holds
    wa(64);
    bus.cs = 1; bus.wr = 1; bus.rd = 1; bus.data_in = 8'h02;
    @(negedge clk);
    idle();
    chk("wr_rd_hold", bus.data_out, 8'h02);
    wa(64); rx(2, "wr_rd_mode");

    // mac twice: 16*16 wraps to 0
    reset_pulse();
    wa(0);
    for (int i = 0; i < 64; i++) wd(16);
    wd(3);
    go(); wait_done(n);
    go(); wait_done(n);
    wa(66);
    for (int i = 0; i < 32; i++) rx(0, "res_mac");

    // sub 1-2 = 0xFF, ptr wraps after 32
    reset_pulse();
    wa(0);
    for (int i = 0; i < 32; i++) wd(1);
    for (int i = 0; i < 32; i++) wd(2);
    wd(1);
    go(); wait_done(n);
    wa(66);
    for (int i = 0; i < 33; i++) rx(8'hff, "res_sub");

    // writes and restart during EXEC are dropped and flag err
    wa(0);
    go();
    wd(8'h55);
    go();
    wa(65);
    rx(5, "stat_err");
    rx(1, "stat_clr");
    wa(66);
    rx(0, "res_exec");
    wait_done(n);
    rx(8'hff, "res_ptr_held");
    wa(0); rx(1, "a0_kept");

    // async reset mid-run
    go();
    repeat (2) @(negedge clk);
    chk("busy_pre", {7'b0, bus.busy}, 8'h01);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_busy", {7'b0, bus.busy}, 8'h00);
    chk("rst_mid_dout", bus.data_out, 8'h00);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    wa(65); rx(0, "stat_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
